// File: rtl/ibus_burst_responder_if.sv
// Bus bundle for the instruction-fetch responder: icache fill port (omem_*)
// plus the downstream 16-bit program memory port (mem_*).
interface ibus_burst_responder_if #(
  parameter int RW     = 16,
  parameter int I_SIZE = 32
);
  logic              omem_req;
  logic [RW-1:0]     omem_addr;
  logic              omem_burst4;
  logic [I_SIZE-1:0] omem_data;
  logic              omem_ack;
  logic              mem_req;
  logic [RW:0]       mem_addr;
  logic [15:0]       mem_data;
  logic              mem_ack;

  modport slave (
    input  omem_req, omem_addr, omem_burst4, mem_data, mem_ack,
    output omem_data, omem_ack, mem_req, mem_addr
  );

  // Environment side: the icache requester together with the memory controller.
  modport master (
    output omem_req, omem_addr, omem_burst4, mem_data, mem_ack,
    input  omem_data, omem_ack, mem_req, mem_addr
  );
endinterface

// File: rtl/ibus_burst_responder.sv
// Serves single-word and wrapping 4-word instruction fetches, building each
// 32-bit word from two 16-bit reads on the downstream req/ack memory port.
module ibus_burst_responder #(
  parameter int RW     = 16,
  parameter int I_SIZE = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  ibus_burst_responder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RD_LO,
    RD_HI,
    ACK
  } state_e;

  state_e            state_q, state_d;
  logic [RW-1:0]     base_q, base_d;
  logic              burst_q, burst_d;
  logic [1:0]        beat_q, beat_d;
  logic              half_q, half_d;
  logic [15:0]       lo_q, lo_d;
  logic [I_SIZE-1:0] data_q, data_d;
  logic              ack_q, ack_d;
  logic              memReq_q, memReq_d;
  logic [RW:0]       memAddr_q, memAddr_d;
  logic [1:0]        beatInc;

  // Word offset wraps inside the aligned 4-word line; upper bits never carry.
  function automatic logic [RW:0] halfAddr(input logic [RW-1:0] b,
                                           input logic [1:0]    bt,
                                           input logic          h);
    logic [1:0] off;
    off = b[1:0] + bt;
    return {b[RW-1:2], off, h};
  endfunction

  assign beatInc = beat_q + 2'd1;

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    burst_d   = burst_q;
    beat_d    = beat_q;
    half_d    = half_q;
    lo_d      = lo_q;
    data_d    = data_q;
    ack_d     = 1'b0;
    memReq_d  = memReq_q;
    memAddr_d = memAddr_q;

    unique case (state_q)
      IDLE: begin
        if (bus.omem_req) begin
          base_d    = bus.omem_addr;
          burst_d   = bus.omem_burst4;
          beat_d    = 2'd0;
          half_d    = 1'b0;
          memReq_d  = 1'b1;
          memAddr_d = halfAddr(bus.omem_addr, 2'd0, 1'b0);
          state_d   = RD_LO;
        end
      end
      RD_LO: begin
        if (bus.mem_ack) begin
          lo_d      = bus.mem_data;
          half_d    = 1'b1;
          memAddr_d = halfAddr(base_q, beat_q, 1'b1);
          state_d   = RD_HI;
        end
      end
      RD_HI: begin
        if (bus.mem_ack) begin
          memReq_d = 1'b0;
          data_d   = {bus.mem_data, lo_q};
          ack_d    = 1'b1;
          state_d  = ACK;
        end
      end
      ACK: begin
        half_d = 1'b0;
        // The requester's own address counter is ignored; beat drives the next word.
        if (burst_q && beat_q != 2'd3) begin
          beat_d    = beatInc;
          memReq_d  = 1'b1;
          memAddr_d = halfAddr(base_q, beatInc, 1'b0);
          state_d   = RD_LO;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      base_q    <= '0;
      burst_q   <= 1'b0;
      beat_q    <= 2'd0;
      half_q    <= 1'b0;
      lo_q      <= '0;
      data_q    <= '0;
      ack_q     <= 1'b0;
      memReq_q  <= 1'b0;
      memAddr_q <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      burst_q   <= burst_d;
      beat_q    <= beat_d;
      half_q    <= half_d;
      lo_q      <= lo_d;
      data_q    <= data_d;
      ack_q     <= ack_d;
      memReq_q  <= memReq_d;
      memAddr_q <= memAddr_d;
    end
  end

  assign bus.omem_data = data_q;
  assign bus.omem_ack  = ack_q;
  assign bus.mem_req   = memReq_q;
  assign bus.mem_addr  = memAddr_q;

endmodule

// File: tb/tb_ibus_burst_responder.sv
// Bench for ibus_burst_responder: icache-style requester, registered program
// memory with programmable wait states, and a line-wrap reference model.
module tb_ibus_burst_responder;
  localparam int RW = 16;

  logic        i_clk = 1'b0;
  logic        i_rst;
  int          total = 0;
  int          bad = 0;
  int          cycleCount = 0;
  int          waitStates = 0;
  int          waitCnt = 0;
  logic        memAckQ = 1'b0;
  logic [15:0] memDataQ = '0;
  logic        strayAck = 1'b0;
  logic [15:0] memArr [0:131071];
  logic [16:0] obsAddr[$];
  logic [16:0] expAddr[$];
  logic [31:0] obsData[$];
  logic [31:0] expData[$];
  int          ackCycles[$];
  int          stableViol = 0;
  logic        prevReq = 1'b0;
  logic        prevAck = 1'b0;
  logic [16:0] prevAddr = '0;

  ibus_burst_responder_if #(.RW(RW), .I_SIZE(32)) bus ();

  ibus_burst_responder #(.RW(RW), .I_SIZE(32)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  assign bus.mem_ack  = memAckQ | strayAck;
  assign bus.mem_data = memDataQ;

  always @(posedge i_clk) cycleCount <= cycleCount + 1;

  // Program memory: acks one cycle after seeing a request, plus waitStates extra cycles.
  always @(posedge i_clk) begin
    if (i_rst) begin
      memAckQ <= 1'b0;
      waitCnt <= 0;
    end else if (memAckQ) begin
      memAckQ <= 1'b0;
      waitCnt <= 0;
    end else if (bus.mem_req === 1'b1) begin
      if (waitCnt >= waitStates) begin
        memAckQ  <= 1'b1;
        memDataQ <= memArr[bus.mem_addr];
        obsAddr.push_back(bus.mem_addr);
      end else begin
        waitCnt <= waitCnt + 1;
      end
    end
  end

  always @(negedge i_clk) begin
    if (bus.omem_ack === 1'b1) begin
      obsData.push_back(bus.omem_data);
      ackCycles.push_back(cycleCount);
    end
    if (i_rst !== 1'b1 && prevReq && !prevAck &&
        (bus.mem_req !== 1'b1 || bus.mem_addr !== prevAddr))
      stableViol = stableViol + 1;
    prevReq  = (bus.mem_req === 1'b1);
    prevAck  = (bus.mem_ack === 1'b1);
    prevAddr = bus.mem_addr;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want)
    else begin
      bad++;
      $error("[TB] FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  task automatic clearQueues();
    obsAddr.delete();
    expAddr.delete();
    obsData.delete();
    expData.delete();
    ackCycles.delete();
  endtask

  // Reference: word offset (base+beat) mod 4 inside the base's aligned line.
  task automatic expectTxn(input int addr, input int burst);
    int n;
    int w;
    n = (burst != 0) ? 4 : 1;
    for (int b = 0; b < n; b++) begin
      w = (addr & ~3) | ((addr + b) & 3);
      expAddr.push_back(17'(2 * w));
      expAddr.push_back(17'(2 * w + 1));
      expData.push_back({memArr[2 * w + 1], memArr[2 * w]});
    end
  endtask

  // Icache-style requester: holds req, bumps its own address after each ack,
  // drops req while the final ack is on the bus.
  task automatic applyStimulus(input logic [15:0] addr, input logic burst,
                               input int waits, output int latency);
    int nBeats;
    int got;
    int budget;
    int start;
    nBeats  = burst ? 4 : 1;
    got     = 0;
    budget  = 0;
    latency = -1;
    waitStates      = waits;
    bus.omem_addr   = addr;
    bus.omem_burst4 = burst;
    bus.omem_req    = 1'b1;
    start = cycleCount;
    while (got < nBeats && budget < 500) begin
      @(negedge i_clk);
      budget++;
      if (bus.omem_ack === 1'b1) begin
        got++;
        if (got == 1) latency = cycleCount - start;
        bus.omem_addr   = bus.omem_addr + 16'd1;
        bus.omem_burst4 = ~bus.omem_burst4;
        if (got == nBeats) bus.omem_req = 1'b0;
      end
    end
    bus.omem_req = 1'b0;
    chk("acks before timeout", 32'(got), 32'(nBeats));
    repeat (3) @(negedge i_clk);
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, " words"}, 32'(obsData.size()), 32'(expData.size()));
    chk({tag, " halves"}, 32'(obsAddr.size()), 32'(expAddr.size()));
    for (int i = 0; i < expData.size(); i++)
      chk($sformatf("%s word%0d", tag, i), obsData[i], expData[i]);
    for (int i = 0; i < expAddr.size(); i++)
      chk($sformatf("%s addr%0d", tag, i), 32'(obsAddr[i]), 32'(expAddr[i]));
    for (int i = 1; i < ackCycles.size(); i++)
      chk($sformatf("%s spacing%0d", tag, i),
          32'(ackCycles[i] - ackCycles[i-1] >= 3), 32'd1);
    chk({tag, " mem_req idle"}, 32'(bus.mem_req), 32'd0);
    clearQueues();
  endtask

  initial begin
    int lat;
    int got;
    int budget;
    logic [15:0] a1;
    logic [15:0] a2;

    for (int a = 0; a < 131072; a++) memArr[a] = 16'($urandom);
    memArr[17'h24] = 16'hBEEF;
    memArr[17'h25] = 16'hDEAD;

    i_rst = 1'b1;
    bus.omem_req = 1'b0;
    bus.omem_addr = '0;
    bus.omem_burst4 = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("reset omem_ack", 32'(bus.omem_ack), 32'd0);
    chk("reset omem_data", bus.omem_data, 32'd0);
    chk("reset mem_req", 32'(bus.mem_req), 32'd0);
    chk("reset mem_addr", 32'(bus.mem_addr), 32'd0);
    i_rst = 1'b0;
    repeat (2) @(negedge i_clk);
    clearQueues();

    $display("[TB] single read at 0x0012");
    expectTxn(32'h12, 0);
    applyStimulus(16'h0012, 1'b0, 0, lat);
    chk("single latency", 32'(lat), 32'd5);
    chk("single literal", obsData[0], 32'hDEADBEEF);
    checkOutput("single");

    $display("[TB] burst line fill at 0x0040");
    expectTxn(32'h40, 1);
    applyStimulus(16'h0040, 1'b1, 0, lat);
    chk("burst first halfaddr", 32'(obsAddr[0]), 32'h80);
    chk("burst last halfaddr", 32'(obsAddr[7]), 32'h87);
    checkOutput("burst");

    $display("[TB] wrapping burst at 0x0006");
    expectTxn(32'h6, 1);
    applyStimulus(16'h0006, 1'b1, 0, lat);
    chk("wrap first halfaddr", 32'(obsAddr[0]), 32'h0C);
    chk("wrap wrapped halfaddr", 32'(obsAddr[4]), 32'h08);
    checkOutput("wrap");

    $display("[TB] burst with wait states");
    a1 = 16'($urandom);
    expectTxn(int'(a1), 1);
    applyStimulus(a1, 1'b1, 3, lat);
    checkOutput("waits");
    chk("waits request stable", 32'(stableViol), 32'd0);

    $display("[TB] reset during RD_HI of beat 2");
    a1 = 16'($urandom);
    waitStates = 2;
    bus.omem_addr = a1;
    bus.omem_burst4 = 1'b1;
    bus.omem_req = 1'b1;
    got = 0;
    budget = 0;
    while (budget < 500 && !(got == 2 && bus.mem_req === 1'b1 && bus.mem_addr[0] === 1'b1)) begin
      @(negedge i_clk);
      budget++;
      if (bus.omem_ack === 1'b1) got++;
    end
    chk("reset point reached", 32'(got), 32'd2);
    i_rst = 1'b1;
    bus.omem_req = 1'b0;
    @(negedge i_clk);
    chk("midreset omem_ack", 32'(bus.omem_ack), 32'd0);
    chk("midreset mem_req", 32'(bus.mem_req), 32'd0);
    chk("midreset mem_addr", 32'(bus.mem_addr), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("partial line acks", 32'(obsData.size()), 32'd2);
    clearQueues();
    @(negedge i_clk);
    strayAck = 1'b1;
    @(negedge i_clk);
    strayAck = 1'b0;
    repeat (4) @(negedge i_clk);
    chk("stray ack no omem_ack", 32'(obsData.size()), 32'd0);
    chk("stray ack no mem_req", 32'(obsAddr.size()), 32'd0);
    clearQueues();
    expectTxn(32'h12, 0);
    applyStimulus(16'h0012, 1'b0, 0, lat);
    chk("post-reset latency", 32'(lat), 32'd5);
    checkOutput("post-reset");

    $display("[TB] back-to-back single reads");
    a1 = 16'($urandom);
    a2 = 16'($urandom);
    expectTxn(int'(a1), 0);
    expectTxn(int'(a2), 0);
    waitStates = 0;
    bus.omem_addr = a1;
    bus.omem_burst4 = 1'b0;
    bus.omem_req = 1'b1;
    got = 0;
    budget = 0;
    while (got < 2 && budget < 500) begin
      @(negedge i_clk);
      budget++;
      if (bus.omem_ack === 1'b1) begin
        got++;
        if (got == 1) bus.omem_addr = a2;
        else bus.omem_req = 1'b0;
      end
    end
    bus.omem_req = 1'b0;
    chk("b2b acks", 32'(got), 32'd2);
    repeat (3) @(negedge i_clk);
    checkOutput("b2b");

    $display("[TB] random transactions");
    for (int t = 0; t < 8; t++) begin
      logic rb;
      int rw;
      a1 = 16'($urandom);
      rb = 1'($urandom_range(0, 1));
      rw = $urandom_range(0, 3);
      expectTxn(int'(a1), int'(rb));
      applyStimulus(a1, rb, rw, lat);
      checkOutput($sformatf("rand%0d", t));
    end
    chk("request stable overall", 32'(stableViol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
